instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/ifetch_pkg.sv | 14 +
 rtl/ifetch_fifo.sv | 56 +++++
 rtl/instr_fetch.sv | 92 +++++++++
 tb/tb_instr_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro used by instr_fetch: IFETCH_PERF_CNT_EN.
package ifetch_pkg;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

  localparam int          IFETCH_DEPTH    = 4;
  localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INC          = 32'd4;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue holding {pc, instr} pairs; the head is read straight from storage registers.
// flush empties the queue and wins over push/pop in the same cycle.
module ifetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues word fetches with one-cycle memory latency into a prefetch queue.
// Define IFETCH_PERF_CNT_EN to add the stall_cnt performance counter output.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = IFETCH_DEPTH,
  parameter logic [31:0] RESET_PC = IFETCH_RESET_PC
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic [31:0]  imem_rdata,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         instr_valid,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc,
  input  logic         instr_ready,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0]  stall_cnt,
`endif
  output fetch_state_e state
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  // Handshake: instr is consumed on a rising edge where instr_valid and instr_ready are both 1;
  // instr_valid never depends on instr_ready, and once high it stays high until the transfer or a redirect.
  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight_q;
  logic          pop;
  logic          can_req;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occ_sum;
  logic [CW:0]   next_total;
  logic [63:0]   head;

  assign pop         = instr_valid & instr_ready;
  assign occ_sum     = {1'b0, fifo_count} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
  assign can_req     = (occ_sum < DEPTH_V);
  assign imem_req    = reset & (redirect_valid | can_req);
  assign imem_addr   = redirect_valid ? {redirect_pc[31:2], 2'b00} : fetch_pc;
  assign next_total  = occ_sum + (CW + 1)'(imem_req);
  assign instr_valid = ~fifo_empty;
  assign {instr_pc, instr} = head;

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .W     (64)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (inflight_q & ~redirect_valid & ~fifo_full),
    .pop   (pop & ~redirect_valid),
    .wdata ({inflight_pc, imem_rdata}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // HOLD means queue plus in-flight slots are all taken after this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= {RESET_PC[31:2], 2'b00};
      inflight_q  <= 1'b0;
      inflight_pc <= '0;
      state       <= ST_FETCH;
    end else begin
      inflight_q  <= imem_req;
      inflight_pc <= imem_addr;
      if (imem_req) fetch_pc <= imem_addr + PC_INC;
      if (redirect_valid)           state <= ST_FETCH;
      else if (next_total == DEPTH_V) state <= ST_HOLD;
      else                          state <= ST_FETCH;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        stall_cnt <= '0;
    else if (instr_valid & ~instr_ready) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch against a fetch-stream scoreboard.
// Covers IFETCH_PERF_CNT_EN builds as well as the default build.
module tb_instr_fetch;
  import ifetch_pkg::*;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_rdata = 32'hDEAD_BEEF;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = '0;
  logic         instr_valid;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  logic         instr_ready = 1'b0;
  fetch_state_e state;

  logic         w_imem_req;
  logic [31:0]  w_imem_addr;
  logic         w_instr_valid;
  logic [31:0]  w_instr;
  logic [31:0]  w_instr_pc;
  fetch_state_e w_state;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  w_stall_cnt;
`endif

  // clock / reset
  always #5 clk = ~clk;

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
`ifdef IFETCH_PERF_CNT_EN
    .stall_cnt      (stall_cnt),
`endif
    .state          (state)
  );

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (w_imem_req),
    .imem_addr      (w_imem_addr),
    .imem_rdata     (32'h0000_0000),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0000_0000),
    .instr_valid    (w_instr_valid),
    .instr          (w_instr),
    .instr_pc       (w_instr_pc),
    .instr_ready    (1'b1),
`ifdef IFETCH_PERF_CNT_EN
    .stall_cnt      (w_stall_cnt),
`endif
    .state          (w_state)
  );

  // scoreboard: addresses issued and not yet delivered, with the cycle each was issued
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] model_pc;
  int          cyc;
  int          stall_m;
  logic        prev_req;
  logic [31:0] prev_addr;
  int          wrap_cnt;
  int          n_xfer;
  logic        chk_redir_first;
  logic        seq_chk;
  logic        have_last;
  logic [31:0] last_pc;
  int          n_assert = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input logic [31:0] start_pc);
    exp_q.delete();
    exp_cyc_q.delete();
    model_pc = start_pc;
  endtask

  // one clock cycle: drive inputs at negedge, check outputs 1 time unit later
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic        exp_valid;
    logic        exp_req;
    logic [31:0] exp_addr;
    @(negedge clk);
    reset          = 1'b1;
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rdata     = prev_req ? prev_addr : 32'hDEAD_BEEF;
    #1;
    exp_valid = (exp_q.size() > 0) && ((cyc - exp_cyc_q[0]) >= 2);
    chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("instr_pc", instr_pc, exp_q[0]);
      chk("instr", instr, exp_q[0]);
    end
`ifdef IFETCH_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 32'(stall_m));
`endif
    if (exp_valid && !rdy) stall_m++;
    if (redir) begin
      model_clear(32'h0);
      exp_req  = 1'b1;
      exp_addr = {rpc[31:2], 2'b00};
    end else begin
      if (exp_valid && rdy) begin
        if (chk_redir_first) begin
          chk("redir_first_pc", instr_pc, 32'h0000_0100);
          chk_redir_first = 1'b0;
        end
        if (seq_chk && have_last) chk("pc_plus4", instr_pc, last_pc + 32'd4);
        last_pc   = exp_q[0];
        have_last = 1'b1;
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
        n_xfer++;
      end
      exp_req  = (exp_q.size() < DEPTH);
      exp_addr = model_pc;
    end
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) begin
      chk("imem_addr", imem_addr, exp_addr);
      exp_q.push_back(exp_addr);
      exp_cyc_q.push_back(cyc);
      model_pc = exp_addr + 32'd4;
    end
    if (wrap_cnt < 3) begin
      chk("wrap_req", 32'(w_imem_req), 32'd1);
      chk("wrap_addr", w_imem_addr, 32'hFFFF_FFF8 + 32'(4 * wrap_cnt));
      wrap_cnt++;
    end
    prev_req  = imem_req;
    prev_addr = imem_addr;
    cyc++;
  endtask

  // reset asserted mid-cycle to show it acts without a clock edge
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("rst_state", 32'(state), 32'(ST_FETCH));
`ifdef IFETCH_PERF_CNT_EN
      chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    end
    model_clear(32'h0000_0000);
    cyc       = 0;
    stall_m   = 0;
    prev_req  = 1'b0;
    prev_addr = '0;
    wrap_cnt  = 0;
  endtask

  initial begin
    int s_start;
    int budget;
    n_xfer          = 0;
    chk_redir_first = 1'b0;
    seq_chk         = 1'b0;
    have_last       = 1'b0;
    last_pc         = '0;
    do_reset();

    // sequential stream with downstream always ready
    repeat (12) step(1'b1, 1'b0, 32'h0);

    // downstream stalls for 10 cycles; queue and in-flight slot fill up
    s_start = stall_m;
    repeat (10) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("hold_state", 32'(state), 32'(ST_HOLD));
    chk("hold_no_req", 32'(imem_req), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
    chk("stall_10", stall_cnt, 32'(s_start + 10));
`endif
    repeat (8) step(1'b1, 1'b0, 32'h0);

    // redirect while full
    repeat (6) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0103);
    chk_redir_first = 1'b1;
    step(1'b1, 1'b0, 32'h0);
    chk("redir_valid_low", 32'(instr_valid), 32'd0);
    repeat (8) step(1'b1, 1'b0, 32'h0);
    chk("redir_first_seen", 32'(chk_redir_first), 32'd0);

    // reset with a backlog of queued words
    repeat (5) step(1'b0, 1'b0, 32'h0);
    do_reset();
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // random backpressure over 1000 transfers
    seq_chk   = 1'b1;
    have_last = 1'b0;
    n_xfer    = 0;
    budget    = 6000;
    while (n_xfer < 1000 && budget > 0) begin
      step(1'($urandom_range(0, 1)), 1'b0, 32'h0);
      budget--;
    end
    chk("xfer_budget", 32'(n_xfer >= 1000), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
